// File: rtl/exec_divider_pkg.sv
// Shared definitions for the Execute-stage iterative divider: FSM encodings
// and the constants of the default 32-bit configuration.
package exec_divider_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = DIV_WIDTH;
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_LO = {DIV_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/exec_divider_if.sv
// Execute-stage <-> divider signal bundle. The pipeline (master) holds StartE
// high while stalled by DivBusyE; HasDivE is a one-cycle result strobe with
// DivLoE/DivHiE valid in that cycle.
interface exec_divider_if #(
   parameter int WIDTH = 32
);
   logic             StartE;
   logic             IsSignedE;
   logic [WIDTH-1:0] SrcAE;
   logic [WIDTH-1:0] SrcBE;
   logic             FlushE;
   logic             DivBusyE;
   logic             HasDivE;
   logic [WIDTH-1:0] DivLoE;
   logic [WIDTH-1:0] DivHiE;

   modport master (
      output StartE, IsSignedE, SrcAE, SrcBE, FlushE,
      input  DivBusyE, HasDivE, DivLoE, DivHiE
   );

   modport slave (
      input  StartE, IsSignedE, SrcAE, SrcBE, FlushE,
      output DivBusyE, HasDivE, DivLoE, DivHiE
   );
endinterface

// File: rtl/exec_divider_div_step.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract the
// divisor with a WIDTH+1-bit compare, and shift the quotient bit in.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);
   logic [WIDTH:0] w_shift;
   logic           w_ge;

   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, i_divisor});
   // rem < divisor holds on entry, so the difference always fits in WIDTH bits.
   assign o_rem   = w_ge ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
   assign o_quo   = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/exec_divider.sv
// Iterative radix-2 divider for MIPS div/divu: stalls Execute for WIDTH+1
// cycles, then strobes HasDivE with registered quotient (LO) and remainder (HI).
module exec_divider
   import exec_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   exec_divider_if.slave        div_if,
   output div_state_e           o_dbg_state
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_src_a;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;

   logic             w_busy;
   logic             w_has_div;
   logic             w_start;
   logic             w_step;
   logic             w_last;
   logic             w_sign_a;
   logic             w_sign_b;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_lo_fix;
   logic [WIDTH-1:0] w_hi_fix;

   assign w_sign_a = div_if.IsSignedE & div_if.SrcAE[WIDTH-1];
   assign w_sign_b = div_if.IsSignedE & div_if.SrcBE[WIDTH-1];
   assign w_abs_a  = w_sign_a ? (~div_if.SrcAE + 1'b1) : div_if.SrcAE;
   assign w_abs_b  = w_sign_b ? (~div_if.SrcBE + 1'b1) : div_if.SrcBE;

   assign w_start = (r_state == DIV_IDLE) && div_if.StartE && !div_if.FlushE;
   assign w_step  = (r_state == DIV_RUN) && !div_if.FlushE;
   assign w_last  = w_step && (r_cnt == CNT_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_has_div   = 1'b0;
      unique case (r_state)
         DIV_IDLE: begin
            if (w_start) begin
               w_state_nxt = DIV_RUN;
               w_busy      = 1'b1;
            end
         end
         DIV_RUN: begin
            w_busy = 1'b1;
            if (w_last) w_state_nxt = DIV_DONE;
         end
         DIV_DONE: begin
            // StartE still high here belongs to the finishing instruction.
            w_has_div   = !div_if.FlushE;
            w_state_nxt = DIV_IDLE;
         end
         default: w_state_nxt = DIV_IDLE;
      endcase
      if (div_if.FlushE) w_state_nxt = DIV_IDLE;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= DIV_IDLE;
      else        r_state <= w_state_nxt;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_nxt),
      .o_quo     (w_quo_nxt)
   );

   // Divide-by-zero bypasses the sign fix-up and reports the raw dividend.
   assign w_lo_fix = r_div_zero ? {WIDTH{1'b1}}
                   : (r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt);
   assign w_hi_fix = r_div_zero ? r_src_a
                   : (r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_divisor  <= '0;
         r_src_a    <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_lo       <= '0;
         r_hi       <= '0;
      end else if (w_start) begin
         r_cnt      <= CNT_W'(WIDTH);
         r_rem      <= '0;
         r_quo      <= w_abs_a;
         r_divisor  <= w_abs_b;
         r_src_a    <= div_if.SrcAE;
         r_neg_q    <= w_sign_a ^ w_sign_b;
         r_neg_r    <= w_sign_a;
         r_div_zero <= (div_if.SrcBE == '0);
      end else if (w_step) begin
         r_cnt <= r_cnt - 1'b1;
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         if (w_last) begin
            r_lo <= w_lo_fix;
            r_hi <= w_hi_fix;
         end
      end
   end

   assign div_if.DivBusyE = w_busy;
   assign div_if.HasDivE  = w_has_div;
   assign div_if.DivLoE   = r_lo;
   assign div_if.DivHiE   = r_hi;
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_exec_divider.sv
// Directed bench for exec_divider: the driver pushes hand-computed {LO,HI}
// into a queue, a negedge monitor pops and compares on every HasDivE strobe.
module tb_exec_divider;
  import exec_divider_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W;

  logic clk;
  logic rst_n;
  div_state_e dbg_state;

  exec_divider_if #(.WIDTH(W)) dif ();

  exec_divider #(.WIDTH(W)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .div_if      (dif),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int prev_strobe_cyc = 0;
  int last_strobe_cyc = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && dif.HasDivE) begin
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=1 required=0 lo=%h hi=%h", dif.DivLoE, dif.DivHiE);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("result_lo", dif.DivLoE, e[EW-1:W]);
        chk("result_hi", dif.DivHiE, e[W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic run_div(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi);
    int busy_cyc;
    int guard;
    @(negedge clk);
    exp_q.push_back({elo, ehi});
    dif.StartE    = 1'b1;
    dif.IsSignedE = sgn;
    dif.SrcAE     = a;
    dif.SrcBE     = b;
    #1;
    busy_cyc = 0;
    guard    = 0;
    while (dif.DivBusyE && guard < 100) begin
      busy_cyc++;
      guard++;
      @(negedge clk);
      #1;
    end
    chk({name, "_busy_cycles"}, W'(busy_cyc), W'(33));
    chk({name, "_strobe"}, W'(dif.HasDivE), W'(1));
  endtask

  // Called in the DONE cycle with StartE still high; it must not restart.
  task automatic finish_div(input string name);
    @(negedge clk);
    chk({name, "_back_idle"}, W'(dbg_state), W'(DIV_IDLE));
    chk({name, "_strobe_gone"}, W'(dif.HasDivE), W'(0));
    dif.StartE = 1'b0;
    #1;
    chk({name, "_busy_low"}, W'(dif.DivBusyE), W'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    dif.StartE    = 1'b0;
    dif.IsSignedE = 1'b0;
    dif.SrcAE     = '0;
    dif.SrcBE     = '0;
    dif.FlushE    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", W'(dbg_state), W'(DIV_IDLE));
    chk("rst_lo", dif.DivLoE, '0);
    chk("rst_hi", dif.DivHiE, '0);
    chk("rst_has", W'(dif.HasDivE), W'(0));
    chk("rst_busy", W'(dif.DivBusyE), W'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    finish_div("divu_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    finish_div("div_m7_2");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    finish_div("div_7_m2");
    run_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    finish_div("div_m7_m2");
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    finish_div("divu_max_1");
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    finish_div("div_ovf");
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, DIV_ZERO_LO, 32'd5);
    finish_div("divu_5_0");
    run_div("div_5_0", 1'b1, 32'd5, 32'd0, DIV_ZERO_LO, 32'd5);
    finish_div("div_5_0");
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, DIV_ZERO_LO, 32'hFFFF_FFFB);
    finish_div("div_m5_0");

    // back-to-back: second start lands in IDLE right after DONE
    run_div("b2b_20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2);
    run_div("b2b_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
    finish_div("b2b_9_4");
    chk("b2b_spacing", W'(last_strobe_cyc - prev_strobe_cyc), W'(34));

    // flush at T10
    @(negedge clk);
    dif.StartE    = 1'b1;
    dif.IsSignedE = 1'b0;
    dif.SrcAE     = 32'd1000;
    dif.SrcBE     = 32'd3;
    repeat (10) @(negedge clk);
    dif.FlushE = 1'b1;
    dif.StartE = 1'b0;
    @(negedge clk);
    dif.FlushE = 1'b0;
    #1;
    chk("flush_state", W'(dbg_state), W'(DIV_IDLE));
    chk("flush_busy", W'(dif.DivBusyE), W'(0));
    chk("flush_lo_kept", dif.DivLoE, 32'd2);
    chk("flush_hi_kept", dif.DivHiE, 32'd1);
    dif.StartE = 1'b1;
    dif.FlushE = 1'b1;
    #1;
    chk("flush_prio_busy", W'(dif.DivBusyE), W'(0));
    @(negedge clk);
    chk("flush_prio_state", W'(dbg_state), W'(DIV_IDLE));
    dif.StartE = 1'b0;
    dif.FlushE = 1'b0;
    repeat (40) @(negedge clk);

    // reset at T20
    dif.StartE = 1'b1;
    dif.SrcAE  = 32'd50;
    dif.SrcBE  = 32'd5;
    repeat (20) @(negedge clk);
    rst_n      = 1'b0;
    dif.StartE = 1'b0;
    #1;
    chk("midrst_lo", dif.DivLoE, '0);
    chk("midrst_hi", dif.DivHiE, '0);
    chk("midrst_has", W'(dif.HasDivE), W'(0));
    chk("midrst_busy", W'(dif.DivBusyE), W'(0));
    chk("midrst_state", W'(dbg_state), W'(DIV_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exec_divider.md
# exec_divider

Iterative radix-2 divider in the Execute stage, directly upstream of the Memory stage. It serves MIPS `div`/`divu`: it takes the dividend and divisor, stalls the pipeline while it iterates, and presents the quotient (LO) and remainder (HI) with a one-cycle `HasDivE` strobe. The Memory-stage pipeline register captures that strobe and both results on the same edge.

## Interface
- `WIDTH`, default 32: operand and result width.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `StartE` in 1: a div/divu instruction is in Execute. Held high while stalled.
- `IsSignedE` in 1: 1 = `div`, 0 = `divu`. Sampled with `StartE`.
- `SrcAE` in WIDTH: dividend. Sampled with `StartE`.
- `SrcBE` in WIDTH: divisor. Sampled with `StartE`.
- `FlushE` in 1: synchronous abort of the instruction in Execute.
- `DivBusyE` out 1: stall request to the hazard unit.
- `HasDivE` out 1: result valid this cycle; drives the `HasDivE` input of the Memory stage.
- `DivLoE` out WIDTH: quotient, registered.
- `DivHiE` out WIDTH: remainder, registered.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If `StartE` is high and `FlushE` is low: latch |A| and |B| (absolute values only when `IsSignedE`), the sign of A, and sign(A) xor sign(B).
  - Clear the partial remainder, load the iteration counter with WIDTH, go to RUN.
- **RUN**, one restoring step per cycle:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - If rem ≥ divisor: subtract and set quo LSB to 1; otherwise set it to 0.
  - Decrement the counter. When the counter reaches 0 after a step, go to DONE.
- **DONE**
  - `DivLoE`/`DivHiE` were loaded on the RUN→DONE edge with the sign fix-up applied:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - `HasDivE` = 1. Unconditionally return to IDLE on the next edge.
  - `StartE` seen in DONE is the same instruction; ignore it.
- **Arithmetic**
  - Absolute values and negation are WIDTH-bit two's complement.
  - The comparison/subtract is WIDTH+1 bits, so no carry is lost.
- **Divide by zero**: no trap. Results are `DivLoE` = all-ones and `DivHiE` = dividend, with no sign fix-up in either mode.
- **Overflow** (`div` 0x80000000 / 0xFFFFFFFF): `DivLoE` = 0x80000000, `DivHiE` = 0.
- **FlushE**
  - In any state, forces IDLE on the next edge.
  - `HasDivE` stays low, and the result registers keep their previous values.
  - `FlushE` has priority over `StartE`.
- **Reset**: state IDLE, counter 0, `DivLoE` = `DivHiE` = 0, `HasDivE` = 0, `DivBusyE` = 0.
  - Reset in the middle of an operation discards it; there is no output strobe.

## Timing
- `DivBusyE` = (IDLE and `StartE` and not `FlushE`) or RUN. It is combinational, so the stall takes effect in the start cycle.
- Start cycle T0 (IDLE); RUN occupies T1..T32; DONE at T33.
  - `DivBusyE` is high for T0..T32 (33 cycles).
  - `HasDivE` is high during T33 only.
  - The Memory stage captures the results on the T33→T34 edge.
- `DivLoE`/`DivHiE` change only on the RUN→DONE edge and hold until the next completion.
- Back-to-back divides: a new `StartE` is accepted in IDLE at T34 at the earliest.
- `SrcAE`/`SrcBE` are don't-care after T0.

## Structure
- Shared package holds:
  - state encodings `DIV_IDLE`, `DIV_RUN`, `DIV_DONE`;
  - `DIV_ITERS` = WIDTH;
  - `DIV_ZERO_LO` = all-ones.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside the RUN datapath.
- FSM, counter, sign handling and output registers live in `exec_divider`.

## Test plan
- Unsigned divide: `divu` 100 / 7 → `DivLoE` = 14, `DivHiE` = 2. `DivBusyE` is high for exactly 33 cycles, then `HasDivE` pulses for 1 cycle.
- Signed divide, all sign combinations: -7/2 → LO = -3, HI = -1; 7/-2 → LO = -3, HI = 1; -7/-2 → LO = 3, HI = -1.
- Boundaries:
  - `divu` 0xFFFFFFFF/1 → LO = 0xFFFFFFFF, HI = 0.
  - `div` 0x80000000/0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - Divide by zero on 5 (both modes) → LO = 0xFFFFFFFF, HI = 5.
- Abort: `FlushE` at T10 → IDLE next cycle, `DivBusyE` low, no `HasDivE`, outputs unchanged. `RST_N` low at T20 → all outputs 0 immediately, no strobe afterwards.
- Back-to-back: 20/3, then 9/4 started at T34 → two `HasDivE` pulses 34 cycles apart with (6,2) then (2,1). `StartE` held through DONE does not restart the divider.
